// File: rtl/ahbl_defs.sv
// AHB-Lite protocol encodings shared by bus-fabric blocks.
package ahbl_defs;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave to APB master bridge: one APB setup/access per AHB transfer,
// AHB wait states until the completer is ready, APB errors as two-cycle ERROR.
module ahbl_to_apb
  import ahbl_defs::*;
#(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [2:0]         ahbls_hburst,
  input  logic [3:0]         ahbls_hprot,
  input  logic               ahbls_hmastlock,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_SETUP, S_ACCESS, S_RESP, S_ERR1, S_ERR2
  } state_e;

  state_e               state_q, state_d;
  logic                 hready_resp_q, hready_resp_d;
  logic                 hresp_q, hresp_d;
  logic [W_DATA-1:0]    hrdata_q, hrdata_d;
  logic [W_PADDR-1:0]   paddr_q, paddr_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [W_DATA-1:0]    pwdata_q, pwdata_d;
  logic                 xfer_req;

  assign xfer_req = ahbls_hready && htrans_active(ahbls_htrans);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;

    case (state_q)
      S_IDLE, S_RESP, S_ERR2: begin
        if (xfer_req) begin
          paddr_d  = ahbls_haddr[W_PADDR-1:0];
          pwrite_d = ahbls_hwrite;
          state_d  = ahbls_hwrite ? S_WR_DATA : S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        pwdata_d = ahbls_hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        // pslverr only means something on the cycle the completer is ready.
        if (apbm_pready) begin
          if (apbm_pslverr) begin
            state_d  = S_ERR1;
            hrdata_d = '0;
          end else begin
            state_d  = S_RESP;
            hrdata_d = apbm_prdata;
          end
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they can all be registered.
    psel_d        = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d     = (state_d == S_ACCESS);
    hready_resp_d = (state_d == S_IDLE) || (state_d == S_RESP) || (state_d == S_ERR2);
    hresp_d       = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hready_resp_q <= 1'b1;
      hresp_q       <= HRESP_OKAY;
      hrdata_q      <= '0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      hready_resp_q <= hready_resp_d;
      hresp_q       <= hresp_d;
      hrdata_q      <= hrdata_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
    end
  end

  assign ahbls_hready_resp = hready_resp_q;
  assign ahbls_hresp       = hresp_q;
  assign ahbls_hrdata      = hrdata_q;
  assign apbm_paddr        = paddr_q;
  assign apbm_psel         = psel_q;
  assign apbm_penable      = penable_q;
  assign apbm_pwrite       = pwrite_q;
  assign apbm_pwdata       = pwdata_q;

  // Sideband attributes are not forwarded: every access is a full word.
  logic unused;
  assign unused = ^{ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0], ahbls_hsize,
                    ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Randomized bench for ahbl_to_apb: an AHB master driver, a behavioural APB
// completer with a word memory, and expectations derived from transfer rules.
module tb_ahbl_to_apb;
  import ahbl_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [2:0]  ahbls_hburst;
  logic [3:0]  ahbls_hprot;
  logic        ahbls_hmastlock;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic [15:0] apbm_paddr;
  logic        apbm_psel;
  logic        apbm_penable;
  logic        apbm_pwrite;
  logic [31:0] apbm_pwdata;
  logic [31:0] apbm_prdata   = 32'h0;
  logic        apbm_pready   = 1'b0;
  logic        apbm_pslverr  = 1'b0;

  ahbl_to_apb #(.W_HADDR(32), .W_PADDR(16), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ahbls_hready(ahbls_hready), .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp(ahbls_hresp), .ahbls_haddr(ahbls_haddr), .ahbls_hwrite(ahbls_hwrite),
    .ahbls_htrans(ahbls_htrans), .ahbls_hsize(ahbls_hsize), .ahbls_hburst(ahbls_hburst),
    .ahbls_hprot(ahbls_hprot), .ahbls_hmastlock(ahbls_hmastlock),
    .ahbls_hwdata(ahbls_hwdata), .ahbls_hrdata(ahbls_hrdata),
    .apbm_paddr(apbm_paddr), .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
    .apbm_pwrite(apbm_pwrite), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
    .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Completer model state and what it observed.
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  int          cfg_waits = 0;
  bit          cfg_err   = 1'b0;
  int          acc_cnt   = 0;
  int          apb_count = 0;
  logic [15:0] last_paddr;
  logic        last_pwrite;
  logic [31:0] last_pwdata;
  logic [15:0] setup_addr;
  logic        setup_write;
  logic [31:0] setup_wdata;
  int          stab_viol = 0;
  int          low_run   = 100;
  int          last_gap  = -1;
  bit          tr_psel [64];
  bit          tr_pen  [64];

  always @(negedge clk) begin
    if (!apbm_psel) begin
      low_run++;
    end else begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end
    if (apbm_psel && !apbm_penable) begin
      setup_addr  = apbm_paddr;
      setup_write = apbm_pwrite;
      setup_wdata = apbm_pwdata;
    end
    if (apbm_psel && apbm_penable) begin
      if (apbm_paddr !== setup_addr || apbm_pwrite !== setup_write || apbm_pwdata !== setup_wdata)
        stab_viol++;
      if (acc_cnt >= cfg_waits) begin
        apbm_pready  = 1'b1;
        apbm_pslverr = cfg_err;
        apbm_prdata  = mem[apbm_paddr[5:2]];
        apb_count++;
        last_paddr  = apbm_paddr;
        last_pwrite = apbm_pwrite;
        last_pwdata = apbm_pwdata;
        if (apbm_pwrite && !cfg_err) mem[apbm_paddr[5:2]] = apbm_pwdata;
      end else begin
        apbm_pready  = 1'b0;
        apbm_pslverr = 1'($urandom);
        apbm_prdata  = $urandom;
      end
      acc_cnt++;
    end else begin
      acc_cnt      = 0;
      apbm_pready  = 1'($urandom);
      apbm_pslverr = 1'($urandom);
      apbm_prdata  = $urandom;
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ahbls_htrans = ($urandom_range(0, 1) == 0) ? HTRANS_IDLE : HTRANS_BUSY;
      ahbls_hready = 1'b1;
      ahbls_haddr  = $urandom;
      @(negedge clk);
    end
  endtask

  // Issues one transfer starting at the current negedge; returns at the negedge
  // of the completing cycle so a following call overlaps its address phase.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input bit err, output int lowc);
    int          base_cnt;
    int          exp_low;
    logic        last_low_hresp;
    logic [31:0] exp_rd;
    cfg_waits      = waits;
    cfg_err        = err;
    base_cnt       = apb_count;
    exp_rd         = ref_mem[addr[5:2]];
    last_low_hresp = 1'b0;
    ahbls_haddr  = addr;
    ahbls_hwrite = wr;
    ahbls_htrans = HTRANS_NONSEQ;
    ahbls_hready = 1'b1;
    @(negedge clk);
    ahbls_htrans = HTRANS_IDLE;
    ahbls_hready = 1'b0;
    ahbls_hwdata = wdata;
    ahbls_haddr  = $urandom;
    ahbls_hwrite = 1'($urandom);
    lowc = 0;
    while (ahbls_hready_resp !== 1'b1 && lowc < 64) begin
      tr_psel[lowc]  = apbm_psel;
      tr_pen[lowc]   = apbm_penable;
      last_low_hresp = ahbls_hresp;
      lowc++;
      @(negedge clk);
    end
    ahbls_hready = 1'b1;
    exp_low = (wr ? 3 : 2) + waits + (err ? 1 : 0);
    checks++;
    if (lowc !== exp_low) begin
      errors++;
      $display("FAIL wait_states addr=%h wr=%0d: got %0d low cycles, expected %0d", addr, wr, lowc, exp_low);
    end
    checks++;
    if (ahbls_hresp !== err) begin
      errors++;
      $display("FAIL final_hresp addr=%h: got %0b, expected %0b", addr, ahbls_hresp, err);
    end
    if (err) begin
      checks++;
      if (last_low_hresp !== 1'b1 || ahbls_hrdata !== 32'h0) begin
        errors++;
        $display("FAIL err_response: err1 hresp=%0b hrdata=%h, expected 1 and 0", last_low_hresp, ahbls_hrdata);
      end
    end else if (!wr) begin
      checks++;
      if (ahbls_hrdata !== exp_rd) begin
        errors++;
        $display("FAIL read_data addr=%h: got %h, expected %h", addr, ahbls_hrdata, exp_rd);
      end
    end
    checks++;
    if (apb_count - base_cnt !== 1 || last_paddr !== addr[15:0] || last_pwrite !== wr ||
        (wr && last_pwdata !== wdata)) begin
      errors++;
      $display("FAIL apb_xfer: n=%0d paddr=%h pwrite=%0b pwdata=%h, expected n=1 paddr=%h pwrite=%0b pwdata=%h",
               apb_count - base_cnt, last_paddr, last_pwrite, last_pwdata, addr[15:0], wr, wdata);
    end
    if (wr && !err) ref_mem[addr[5:2]] = wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ahbls_hready = 1'b1; ahbls_htrans = HTRANS_IDLE; ahbls_haddr = '0; ahbls_hwrite = 1'b0;
    ahbls_hwdata = '0; ahbls_hsize = 3'd2; ahbls_hburst = '0; ahbls_hprot = '0; ahbls_hmastlock = 1'b0;
    #12;
    checks++;
    if (ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b0 || ahbls_hrdata !== 32'h0 ||
        apbm_paddr !== 16'h0 || apbm_psel !== 1'b0 || apbm_penable !== 1'b0 ||
        apbm_pwrite !== 1'b0 || apbm_pwdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: hready_resp=%b hresp=%b hrdata=%h paddr=%h psel=%b penable=%b pwrite=%b pwdata=%h, expected 1 0 0 0 0 0 0 0",
               ahbls_hready_resp, ahbls_hresp, ahbls_hrdata, apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_read();
    int lowc;
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    do_xfer(1'b0, 32'h4000_0010, 32'h0, 0, 1'b0, lowc);
    checks++;
    if (!(tr_psel[0] && !tr_pen[0] && tr_psel[1] && tr_pen[1])) begin
      errors++;
      $display("FAIL read_phases: c1 psel/pen=%0b%0b c2 psel/pen=%0b%0b, expected 10 and 11",
               tr_psel[0], tr_pen[0], tr_psel[1], tr_pen[1]);
    end
    idle_cycles(2);
  endtask

  task automatic test_write_waits();
    int lowc;
    do_xfer(1'b1, 32'h4000_0004, 32'h1234_5678, 3, 1'b0, lowc);
    checks++;
    if (stab_viol !== 0) begin
      errors++;
      $display("FAIL apb_stability: got %0d violations, expected 0", stab_viol);
    end
    idle_cycles(1);
    do_xfer(1'b0, 32'h4000_0004, 32'h0, 1, 1'b0, lowc);
    idle_cycles(1);
  endtask

  task automatic test_error();
    int lowc;
    do_xfer(1'b0, 32'h4000_0020, 32'h0, 0, 1'b1, lowc);
    do_xfer(1'b0, 32'h4000_0010, 32'h0, 0, 1'b0, lowc);
    do_xfer(1'b1, 32'h4000_0028, 32'hCAFE_F00D, 2, 1'b1, lowc);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    int lowc;
    do_xfer(1'b1, 32'h4000_0030, 32'hA5A5_1234, 0, 1'b0, lowc);
    do_xfer(1'b0, 32'h4000_0030, 32'h0, 0, 1'b0, lowc);
    checks++;
    if (last_gap !== 1) begin
      errors++;
      $display("FAIL psel_gap: got %0d low cycles between transfers, expected 1", last_gap);
    end
    idle_cycles(1);
  endtask

  task automatic test_idle_busy();
    for (int i = 0; i < 16; i++) begin
      idle_cycles(1);
      checks++;
      if (ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b0 || apbm_psel !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy cycle %0d: hready_resp=%b hresp=%b psel=%b, expected 1 0 0",
                 i, ahbls_hready_resp, ahbls_hresp, apbm_psel);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int lowc;
    cfg_waits = 20;
    cfg_err   = 1'b0;
    ahbls_haddr = 32'h4000_0008; ahbls_hwrite = 1'b0; ahbls_htrans = HTRANS_NONSEQ; ahbls_hready = 1'b1;
    @(negedge clk);
    ahbls_htrans = HTRANS_IDLE;
    ahbls_hready = 1'b0;
    n = 0;
    while (!(apbm_psel && apbm_penable) && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL reach_access: got no ACCESS within 10 cycles, expected ACCESS");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (apbm_psel !== 1'b0 || apbm_penable !== 1'b0 || ahbls_hready_resp !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: psel=%b penable=%b hready_resp=%b, expected 0 0 1",
               apbm_psel, apbm_penable, ahbls_hready_resp);
    end
    ahbls_hready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    do_xfer(1'b0, 32'h4000_0008, 32'h0, 1, 1'b0, lowc);
    idle_cycles(1);
  endtask

  task automatic test_random();
    int          lowc;
    bit          wr;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      idle_cycles($urandom_range(0, 2));
      wr   = 1'($urandom);
      addr = {16'($urandom), 10'h0, 4'($urandom), 2'b00};
      do_xfer(wr, addr, $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0), lowc);
    end
    idle_cycles(1);
    checks++;
    if (stab_viol !== 0) begin
      errors++;
      $display("FAIL apb_stability_random: got %0d violations, expected 0", stab_viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_read();
    test_write_waits();
    test_error();
    test_back_to_back();
    test_idle_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
